// File: rtl/debug_pkg.sv
// Shared types and frame layout for the debug unit: FSM states and word slots of the report frame.
// Purely declarative; no logic, no latency.
package debug_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_SETTLE,
    S_SNAP,
    S_SEND,
    S_WAIT_TX,
    S_HALTED
  } state_t;

  // Word slots inside the report frame; the memory word follows the last register.
  localparam int W_PC     = 0;
  localparam int W_CICLOS = 1;
  localparam int W_REG0   = 2;

endpackage

// File: rtl/debug_frame_mux.sv
// Combinational byte selector over the snapshot words; zero latency, no flow control.
// Byte index -> word index / 4, lane index % 4 (LSB first).
module debug_frame_mux
  import debug_pkg::*;
#(
  parameter int N_BITS = 32,
  parameter int N_REGS = 32
) (
  input  logic [N_BITS-1:0]        i_pc,
  input  logic [N_BITS-1:0]        i_ciclos,
  input  logic [N_BITS*N_REGS-1:0] i_registros,
  input  logic [N_BITS-1:0]        i_data_memory,
  input  logic [7:0]               i_index,
  output logic [7:0]               o_byte
);

  localparam int BPW   = N_BITS / 8;
  localparam int W_MEM = W_REG0 + N_REGS;

  int                w_word;
  int                w_lane;
  logic [N_BITS-1:0] w_word_dat;

  always_comb begin
    w_word     = int'(i_index) / BPW;
    w_lane     = int'(i_index) % BPW;
    w_word_dat = '0;
    if (w_word == W_PC) begin
      w_word_dat = i_pc;
    end else if (w_word == W_CICLOS) begin
      w_word_dat = i_ciclos;
    end else if (w_word >= W_REG0 && w_word < W_MEM) begin
      w_word_dat = i_registros[(w_word - W_REG0)*N_BITS +: N_BITS];
    end else if (w_word == W_MEM) begin
      w_word_dat = i_data_memory;
    end
    o_byte = w_word_dat[w_lane*8 +: 8];
  end

endmodule

// File: rtl/debug_unit.sv
// Debug control/report FSM: decodes UART commands into pipeline run/step controls, then snapshots state
// and streams a 140-byte frame to TX; one byte per start/done handshake, all outputs registered.
module debug_unit
  import debug_pkg::*;
#(
  parameter int         N_BITS   = 32,
  parameter int         N_REGS   = 32,
  parameter logic [7:0] CMD_CONT = 8'h63,
  parameter logic [7:0] CMD_STEP = 8'h73
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_done,
  input  logic                     i_tx_done,
  input  logic [N_BITS-1:0]        i_pc,
  input  logic [N_BITS-1:0]        i_ciclos,
  input  logic [N_BITS*N_REGS-1:0] i_registros,
  input  logic [N_BITS-1:0]        i_data_memory,
  input  logic                     i_halt,
  output logic                     o_valid,
  output logic                     o_exec_mode,
  output logic                     o_step,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_start,
  output logic                     o_busy
);

  localparam int FRAME_BYTES = (N_REGS + 3) * (N_BITS / 8);

  state_t                  r_state, w_state_nxt;
  logic [7:0]              r_idx, w_idx_nxt;
  logic [N_BITS-1:0]       r_pc, r_ciclos, r_mem;
  logic [N_BITS*N_REGS-1:0] r_regs;
  logic                    r_halt_lat;
  logic                    r_valid, r_exec_mode, r_step, r_tx_start, r_busy;
  logic [7:0]              r_tx_data;

  logic [N_BITS-1:0]        w_src_pc, w_src_ciclos, w_src_mem;
  logic [N_BITS*N_REGS-1:0] w_src_regs;
  logic [7:0]               w_byte;
  logic                     w_halt_set;

  // The first byte is loaded on the same edge that captures the snapshot, so read live inputs in SNAP.
  assign w_src_pc     = (r_state == S_SNAP) ? i_pc          : r_pc;
  assign w_src_ciclos = (r_state == S_SNAP) ? i_ciclos      : r_ciclos;
  assign w_src_regs   = (r_state == S_SNAP) ? i_registros   : r_regs;
  assign w_src_mem    = (r_state == S_SNAP) ? i_data_memory : r_mem;
  assign w_halt_set   = i_halt && (r_state == S_RUN || r_state == S_SNAP);

  debug_frame_mux #(.N_BITS(N_BITS), .N_REGS(N_REGS)) u_frame_mux (
    .i_pc          (w_src_pc),
    .i_ciclos      (w_src_ciclos),
    .i_registros   (w_src_regs),
    .i_data_memory (w_src_mem),
    .i_index       (w_idx_nxt),
    .o_byte        (w_byte)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (i_rx_done && i_rx_data == CMD_CONT)      w_state_nxt = S_RUN;
        else if (i_rx_done && i_rx_data == CMD_STEP) w_state_nxt = S_STEP;
      end
      S_RUN:    if (i_halt) w_state_nxt = S_SNAP;
      S_STEP:   w_state_nxt = S_SETTLE;
      S_SETTLE: w_state_nxt = S_SNAP;
      S_SNAP: begin
        w_state_nxt = S_SEND;
        w_idx_nxt   = 8'd0;
      end
      S_SEND:   w_state_nxt = S_WAIT_TX;
      S_WAIT_TX: begin
        if (i_tx_done) begin
          if (r_idx == 8'(FRAME_BYTES - 1)) begin
            w_state_nxt = r_halt_lat ? S_HALTED : S_IDLE;
          end else begin
            w_idx_nxt   = r_idx + 8'd1;
            w_state_nxt = S_SEND;
          end
        end
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_pc        <= '0;
      r_ciclos    <= '0;
      r_regs      <= '0;
      r_mem       <= '0;
      r_halt_lat  <= 1'b0;
      r_valid     <= 1'b0;
      r_exec_mode <= 1'b0;
      r_step      <= 1'b0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (r_state == S_SNAP) begin
        r_pc     <= i_pc;
        r_ciclos <= i_ciclos;
        r_regs   <= i_registros;
        r_mem    <= i_data_memory;
      end
      if (w_halt_set) r_halt_lat <= 1'b1;
      // Outputs are Moore functions of the next state, registered so they align with the state.
      r_valid    <= (w_state_nxt == S_RUN) || (w_state_nxt == S_STEP);
      r_step     <= (w_state_nxt == S_STEP);
      r_tx_start <= (w_state_nxt == S_SEND);
      r_busy     <= (w_state_nxt == S_SNAP) || (w_state_nxt == S_SEND) || (w_state_nxt == S_WAIT_TX);
      if (w_state_nxt == S_SEND) r_tx_data <= w_byte;
      if (w_state_nxt == S_STEP)     r_exec_mode <= 1'b1;
      else if (w_state_nxt == S_RUN) r_exec_mode <= 1'b0;
    end
  end

  assign o_valid     = r_valid;
  assign o_exec_mode = r_exec_mode;
  assign o_step      = r_step;
  assign o_tx_data   = r_tx_data;
  assign o_tx_start  = r_tx_start;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: expected frame bytes are queued when a report is provoked and
// popped as o_tx_start pulses; a responder returns i_tx_done two cycles after each start.
module tb_debug_unit;

  localparam int NB = 32;
  localparam int NR = 32;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b0;
  logic [7:0]        i_rx_data = '0;
  logic              i_rx_done = 1'b0;
  logic              i_tx_done = 1'b0;
  logic [NB-1:0]     i_pc = '0;
  logic [NB-1:0]     i_ciclos = '0;
  logic [NB*NR-1:0]  i_registros = '0;
  logic [NB-1:0]     i_data_memory = '0;
  logic              i_halt = 1'b0;
  logic              o_valid, o_exec_mode, o_step, o_tx_start, o_busy;
  logic [7:0]        o_tx_data;

  always #5 i_clk = ~i_clk;

  debug_unit dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_rx_data     (i_rx_data),
    .i_rx_done     (i_rx_done),
    .i_tx_done     (i_tx_done),
    .i_pc          (i_pc),
    .i_ciclos      (i_ciclos),
    .i_registros   (i_registros),
    .i_data_memory (i_data_memory),
    .i_halt        (i_halt),
    .o_valid       (o_valid),
    .o_exec_mode   (o_exec_mode),
    .o_step        (o_step),
    .o_tx_data     (o_tx_data),
    .o_tx_start    (o_tx_start),
    .o_busy        (o_busy)
  );

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] sb_q[$];
  int         n_start = 0;
  int         n_step = 0;
  int         frame_base = 0;
  logic       prev_step = 1'b0;
  logic [7:0] tx_log[140];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (o_tx_start) begin
      if (sb_q.size() == 0) chk("tx_spurious", 32'(o_tx_start), 32'd0);
      else chk("tx_byte", 32'(o_tx_data), 32'(sb_q.pop_front()));
      if (n_start - frame_base < 140) tx_log[n_start - frame_base] = o_tx_data;
      n_start++;
    end
    if (o_step) begin
      n_step++;
      chk("step_ctl", {30'd0, o_valid, o_exec_mode}, 32'd3);
      chk("step_single", 32'(prev_step), 32'd0);
    end
    prev_step = o_step;
  end

  // TX responder: i_tx_done arrives two cycles after each start.
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_tx_start) begin
        @(posedge i_clk);
        @(posedge i_clk);
        #1 i_tx_done = 1'b1;
        @(posedge i_clk);
        #1 i_tx_done = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge i_clk);
    #1 i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge i_clk);
    #1 i_rx_done = 1'b0;
  endtask

  task automatic load_data(input logic [31:0] pc);
    i_pc     = pc;
    i_ciclos = $urandom;
    for (int k = 0; k < NR; k++) i_registros[32*k +: 32] = $urandom;
    i_registros[32*5 +: 32] = 32'hDEADBEEF;
    i_data_memory = $urandom;
  endtask

  task automatic push_frame();
    logic [31:0] w;
    for (int k = 0; k < NR + 3; k++) begin
      if (k == 0)           w = i_pc;
      else if (k == 1)      w = i_ciclos;
      else if (k < NR + 2)  w = i_registros[32*(k-2) +: 32];
      else                  w = i_data_memory;
      for (int b = 0; b < 4; b++) sb_q.push_back(w[8*b +: 8]);
    end
    frame_base = n_start;
  endtask

  task automatic wait_frame();
    int budget = 0;
    while ((sb_q.size() != 0 || o_busy) && budget < 5000) begin
      tick(1);
      budget++;
    end
    chk("frame_drain", 32'(sb_q.size()), 32'd0);
    chk("frame_idle", 32'(o_busy), 32'd0);
    chk("frame_len", 32'(n_start - frame_base), 32'd140);
  endtask

  task automatic wait_bytes(input int n);
    int budget = 0;
    while (n_start - frame_base < n && budget < 2000) begin
      tick(1);
      budget++;
    end
    chk("reach_byte", 32'(n_start - frame_base >= n), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_mode"},  32'(o_exec_mode), 32'd0);
    chk({tag, "_step"},  32'(o_step), 32'd0);
    chk({tag, "_start"}, 32'(o_tx_start), 32'd0);
    chk({tag, "_data"},  32'(o_tx_data), 32'd0);
    chk({tag, "_busy"},  32'(o_busy), 32'd0);
  endtask

  int s0, st0;

  initial begin
    tick(3);
    chk_all_zero("rst");
    i_reset = 1'b1;
    tick(2);

    // Single step report; inputs scrambled after the snapshot edge.
    load_data(32'h0000_0004);
    push_frame();
    s0 = n_step;
    send_rx(8'h73);
    tick(5);
    i_pc = 32'hFFFF_0000;
    i_registros[32*5 +: 32] = 32'h1234_5678;
    wait_frame();
    chk("step_count", 32'(n_step - s0), 32'd1);
    chk("step_mode_sticky", 32'(o_exec_mode), 32'd1);
    chk("pc_bytes", {tx_log[3], tx_log[2], tx_log[1], tx_log[0]}, 32'h0000_0004);
    chk("reg5_bytes", {tx_log[31], tx_log[30], tx_log[29], tx_log[28]}, 32'hDEADBEEF);

    // Step command during a frame is dropped; the next one is accepted.
    load_data(32'h0000_0008);
    push_frame();
    s0 = n_step;
    send_rx(8'h73);
    wait_bytes(10);
    send_rx(8'h73);
    wait_frame();
    chk("busy_drop_steps", 32'(n_step - s0), 32'd1);
    load_data(32'h0000_000C);
    push_frame();
    send_rx(8'h73);
    wait_frame();
    chk("after_drop_steps", 32'(n_step - s0), 32'd2);

    // Junk byte in IDLE changes nothing.
    s0 = n_step;
    st0 = n_start;
    send_rx(8'h41);
    tick(20);
    chk("junk_valid", 32'(o_valid), 32'd0);
    chk("junk_busy", 32'(o_busy), 32'd0);
    chk("junk_mode", 32'(o_exec_mode), 32'd1);
    chk("junk_starts", 32'(n_start - st0), 32'd0);
    chk("junk_steps", 32'(n_step - s0), 32'd0);

    // Continuous run until halt, then HALTED ignores commands.
    send_rx(8'h63);
    tick(1);
    chk("run_valid", 32'(o_valid), 32'd1);
    chk("run_mode", 32'(o_exec_mode), 32'd0);
    tick(49);
    chk("run_valid_held", 32'(o_valid), 32'd1);
    load_data(32'h0000_0040);
    push_frame();
    i_halt = 1'b1;
    tick(1);
    chk("halt_valid_drop", 32'(o_valid), 32'd0);
    chk("halt_busy", 32'(o_busy), 32'd1);
    wait_frame();
    s0 = n_step;
    st0 = n_start;
    send_rx(8'h73);
    send_rx(8'h63);
    tick(20);
    chk("halted_valid", 32'(o_valid), 32'd0);
    chk("halted_steps", 32'(n_step - s0), 32'd0);
    chk("halted_starts", 32'(n_start - st0), 32'd0);

    // Reset leaves HALTED; then a reset in the middle of a frame aborts it.
    #2 i_reset = 1'b0;
    i_halt = 1'b0;
    tick(2);
    i_reset = 1'b1;
    tick(2);
    load_data(32'h0000_0080);
    push_frame();
    send_rx(8'h73);
    wait_bytes(20);
    #2 i_reset = 1'b0;
    #1;
    chk_all_zero("midrst");
    sb_q.delete();
    tick(3);
    i_reset = 1'b1;
    st0 = n_start;
    tick(40);
    chk("post_rst_starts", 32'(n_start - st0), 32'd0);

    // Recovery after the aborted frame.
    load_data(32'h0000_00A0);
    push_frame();
    send_rx(8'h73);
    wait_frame();
    chk("recover_pc", {tx_log[3], tx_log[2], tx_log[1], tx_log[0]}, 32'h0000_00A0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
